// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller:
// FSM states, per-digit payload, segment bit order and the hex glyph table.
package seg7_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;
  localparam int unsigned SEG_W = SEG_G + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
  } digit_t;

  // Glyphs ordered {g,f,e,d,c,b,a}; b and d are the lower-case forms.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       value_i,
  output logic [SEG_W-1:0] seg_o_c
);

  always_comb begin
    seg_o_c = GLYPH_TABLE[value_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Double-buffered, time-multiplexed 7-segment scan controller with blanking
// dead time between digits. Optional brightness control under SEG7_DIM_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
`ifdef SEG7_DIM_EN
  input  logic [2:0]                    dim,
`endif
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
  input  logic [3:0]                    wr_value,
  input  logic                          wr_dp,
  input  logic                          commit,
  output logic                          commit_pending,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          frame_tick
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  digit_t [NUM_DIGITS-1:0]  shadow_q, shadow_d;
  digit_t [NUM_DIGITS-1:0]  active_q, active_d;
  logic                     pending_q, pending_d;
  logic                     wr_ready_q, wr_ready_d;
  logic [SEG_W-1:0]         seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic [NUM_DIGITS-1:0]    dig_sel_q, dig_sel_d;
  logic                     tick_q, tick_d;

  logic                     wr_in_range;
  logic                     wr_fire;
  logic                     copy_now;
  logic                     dim_off;
  logic [3:0]               show_value;
  logic [SEG_W-1:0]         glyph_c;

  // Non-power-of-two digit counts leave some wr_digit codes unused.
  if (NUM_DIGITS == (2 ** IDX_W)) begin : g_full_range
    assign wr_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range = 32'(wr_digit) < NUM_DIGITS;
  end

`ifdef SEG7_DIM_EN
  // Segments stay lit for (dim+1)/8 of the dwell; dig_sel is not dimmed.
  assign dim_off = 32'(cnt_d) >= ((32'(dim) + 32'd1) * (DWELL_CYCLES / 32'd8));
`else
  assign dim_off = 1'b0;
`endif

  // Scan sequencer: IDLE -> ON(dwell) -> BLANK(dead time) -> next digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (enable) state_d = ST_ON;
      end
      ST_ON: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow writes, commit tracking and shadow-to-active publish.
  assign wr_fire  = wr_valid & wr_ready_q;
  assign copy_now = pending_q & (tick_q | (state_q == ST_IDLE));

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_fire && wr_in_range) begin
      shadow_d[wr_digit] = '{value: wr_value, dp: wr_dp};
    end
    if (copy_now) active_d = shadow_q;
    pending_d  = pending_q ? ~copy_now : commit;
    wr_ready_d = ~pending_d;
  end

  // Decode from next-cycle values so fresh data appears on the first ON cycle.
  assign show_value = active_d[idx_d].value;

  seg7_hex_decode u_hex_decode (
    .value_i (show_value),
    .seg_o_c (glyph_c)
  );

  always_comb begin
    dig_sel_d = '0;
    seg_d     = '0;
    dp_d      = 1'b0;
    tick_d    = (state_d == ST_BLANK) && (idx_d == IDX_LAST) && (cnt_d == BLANK_LAST);
    if (state_d == ST_ON) begin
      dig_sel_d = NUM_DIGITS'(1) << idx_d;
      if (!dim_off) begin
        seg_d = glyph_c;
        dp_d  = active_d[idx_d].dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      wr_ready_q <= 1'b1;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      dig_sel_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      wr_ready_q <= wr_ready_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_sel_q  <= dig_sel_d;
      tick_q     <= tick_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign commit_pending = pending_q;
  assign seg_out        = seg_q;
  assign dp_out         = dp_q;
  assign dig_sel        = dig_sel_q;
  assign frame_tick     = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, dwell 8, blank 2); expected
// display words are queued per cycle and checked with immediate assertions.
module tb_seg7_scan_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 2;
  localparam int FRAME = N * (DW + BL);

  logic       clk;
  logic       rst;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_value;
  logic       wr_dp;
  logic       commit;
  logic       commit_pending;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_sel;
  logic       frame_tick;
`ifdef SEG7_DIM_EN
  logic [2:0] dim;
`endif

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
`ifdef SEG7_DIM_EN
    .dim            (dim),
`endif
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_digit       (wr_digit),
    .wr_value       (wr_value),
    .wr_dp          (wr_dp),
    .commit         (commit),
    .commit_pending (commit_pending),
    .seg_out        (seg_out),
    .dp_out         (dp_out),
    .dig_sel        (dig_sel),
    .frame_tick     (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  glyph_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [3:0]  exp_val [N];
  logic        exp_dp  [N];
  int          seg_on;
  int          ph;
  int          n_tests;
  int          n_fail;
  logic [12:0] sb_q [$];

  // Expected {dig_sel, seg_out, dp_out, frame_tick} for frame phase p.
  function automatic logic [12:0] exp_disp(input int p);
    int k, d, r;
    logic [3:0] dg;
    logic [6:0] sg;
    logic       dv;
    k  = p % FRAME;
    d  = k / (DW + BL);
    r  = k % (DW + BL);
    dg = 4'h0;
    sg = 7'h00;
    dv = 1'b0;
    if (r < DW) begin
      dg = 4'(1 << d);
      if (r < seg_on) begin
        sg = glyph_ref[exp_val[d]];
        dv = exp_dp[d];
      end
    end
    return {dg, sg, dv, (k == FRAME - 1)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step_raw();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk();
    logic [12:0] want;
    ph++;
    sb_q.push_back(exp_disp(ph));
    step_raw();
    want = sb_q.pop_front();
    check($sformatf("disp@%0d", ph), 32'({dig_sel, seg_out, dp_out, frame_tick}), 32'(want));
  endtask

  task automatic run_to(input int target);
    while (ph < target) step_chk();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      exp_val[i] = 4'h0;
      exp_dp[i]  = 1'b0;
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    seg_on   = DW;
    ph       = -1;
    rst      = 1'b1;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_digit = 2'd0;
    wr_value = 4'h0;
    wr_dp    = 1'b0;
    commit   = 1'b0;
`ifdef SEG7_DIM_EN
    dim      = 3'd7;
`endif
    clear_model();

    repeat (3) step_raw();
    check("rst_dig",     32'(dig_sel), 32'h0);
    check("rst_seg",     32'(seg_out), 32'h0);
    check("rst_dp",      32'(dp_out), 32'h0);
    check("rst_tick",    32'(frame_tick), 32'h0);
    check("rst_pending", 32'(commit_pending), 32'h0);
    check("rst_ready",   32'(wr_ready), 32'h1);

    rst = 1'b0;
    step_raw();
    check("idle_dig", 32'(dig_sel), 32'h0);

    // Two plain frames of zeros.
    enable = 1'b1;
    ph = -1;
    run_to(2 * FRAME - 1);

    // Mid-frame write to digit 2 then commit; a write while pending must stall.
    run_to(84);
    wr_valid = 1'b1; wr_digit = 2'd2; wr_value = 4'hA; wr_dp = 1'b1;
    step_chk();
    wr_valid = 1'b0; commit = 1'b1;
    step_chk();
    commit = 1'b0;
    check("pend_set",   32'(commit_pending), 32'h1);
    check("ready_low",  32'(wr_ready), 32'h0);
    run_to(99);
    wr_valid = 1'b1; wr_digit = 2'd2; wr_value = 4'h5; wr_dp = 1'b0;
    step_chk();
    wr_valid = 1'b0;
    check("ready_stall", 32'(wr_ready), 32'h0);
    run_to(3 * FRAME - 1);
    check("pend_at_tick", 32'(commit_pending), 32'h1);
    exp_val[2] = 4'hA;
    exp_dp[2]  = 1'b1;
    step_chk();
    check("pend_clear",  32'(commit_pending), 32'h0);
    check("ready_back",  32'(wr_ready), 32'h1);

    // Commit on the frame_tick cycle waits a full frame.
    run_to(149);
    wr_valid = 1'b1; wr_digit = 2'd0; wr_value = 4'h7; wr_dp = 1'b0;
    step_chk();
    wr_valid = 1'b0;
    run_to(4 * FRAME - 1);
    commit = 1'b1;
    step_chk();
    commit = 1'b0;
    check("pend_tick_commit", 32'(commit_pending), 32'h1);
    run_to(5 * FRAME - 1);
    exp_val[0] = 4'h7;
    step_chk();
    check("pend_next_frame", 32'(commit_pending), 32'h0);

    // Disable while ON digit 1 with a commit pending: IDLE publishes it.
    run_to(204);
    wr_valid = 1'b1; wr_digit = 2'd3; wr_value = 4'hE; wr_dp = 1'b1;
    step_chk();
    wr_valid = 1'b0; commit = 1'b1;
    step_chk();
    commit = 1'b0;
    check("pend_pre_idle", 32'(commit_pending), 32'h1);
    run_to(212);
    enable = 1'b0;
    step_raw();
    check("idle_disp",    32'({dig_sel, seg_out, dp_out, frame_tick}), 32'h0);
    check("idle_pending", 32'(commit_pending), 32'h1);
    step_raw();
    check("idle_disp2",   32'({dig_sel, seg_out, dp_out, frame_tick}), 32'h0);
    check("idle_copied",  32'(commit_pending), 32'h0);
    check("idle_ready",   32'(wr_ready), 32'h1);
    exp_val[3] = 4'hE;
    exp_dp[3]  = 1'b1;
    enable = 1'b1;
    ph = -1;
    run_to(FRAME + 15);

    // Reset mid-frame with a commit pending clears everything.
    commit = 1'b1;
    step_chk();
    commit = 1'b0;
    check("pend_pre_rst", 32'(commit_pending), 32'h1);
    rst = 1'b1;
    step_raw();
    check("mid_rst_disp",    32'({dig_sel, seg_out, dp_out, frame_tick}), 32'h0);
    check("mid_rst_pending", 32'(commit_pending), 32'h0);
    check("mid_rst_ready",   32'(wr_ready), 32'h1);
    rst = 1'b0;
    clear_model();
    ph = -1;
    run_to(FRAME - 1);

`ifdef SEG7_DIM_EN
    dim    = 3'd1;
    seg_on = 2;
    run_to(2 * FRAME - 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
